// File: rtl/fifo_block_pack_pkg.sv
// fifo_block_pack_pkg: shared default geometry and width helper for the block-packing FIFO
//   FIFO_IN_WH  default narrow word width
//   FIFO_RATIO  default narrow words per wide entry
//   FIFO_DEPTH  default number of stored wide entries
//   clog2       ceiling log2, used for pointer, count and lane-index widths
package fifo_block_pack_pkg;
   localparam int FIFO_IN_WH = 32;
   localparam int FIFO_RATIO = 4;
   localparam int FIFO_DEPTH = 4;
   function automatic int clog2(input int v);
      int r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/fifo_block_pack_lane_packer.sv
// fifo_block_pack_lane_packer: gathers RATIO narrow words into one wide word, lane 0 in the MSBs
//   clk, resetn  clock and asynchronous active-low reset
//   flush        synchronous discard of the partially packed lanes
//   accept       a narrow word is taken this cycle
//   wr_data      the narrow word
//   pack_idx     lanes already held (0..RATIO-1)
//   commit       the accepted word completes a block this cycle
//   word         assembled block: held lanes followed by the live word in the last lane
module fifo_block_pack_lane_packer
   import fifo_block_pack_pkg::*;
#(
   parameter int IN_WH = FIFO_IN_WH,
   parameter int RATIO = FIFO_RATIO,
   localparam int IW = clog2(RATIO),
   localparam int OUT_WH = IN_WH * RATIO
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              flush,
   input  logic              accept,
   input  logic [IN_WH-1:0]  wr_data,
   output logic [IW-1:0]     pack_idx,
   output logic              commit,
   output logic [OUT_WH-1:0] word
);
   localparam logic [IW-1:0] LAST = IW'(RATIO - 1);
   logic [(RATIO-1)*IN_WH-1:0] held;
   assign commit = accept && pack_idx == LAST;
   // The last lane is never stored: it is taken straight from wr_data at the commit edge.
   assign word = {held, wr_data};
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         pack_idx <= '0;
         held     <= '0;
      end else if (flush) begin
         pack_idx <= '0;
      end else if (accept) begin
         pack_idx <= commit ? '0 : pack_idx + IW'(1);
         for (int k = 0; k < RATIO - 1; k++)
            if (pack_idx == IW'(k)) held[(RATIO-1-k)*IN_WH-1 -: IN_WH] <= wr_data;
      end
endmodule

// File: rtl/fifo_block_pack.sv
// fifo_block_pack: synchronous FIFO packing RATIO narrow words into each stored wide entry
//   clk, resetn     clock and asynchronous active-low reset
//   flush           synchronous clear of pointers, count, packer and sticky flags
//   wr_en, wr_data  push one narrow word
//   rd_en           pop one wide entry; rd_data/rd_valid appear one cycle later
//   full, empty, almost_full, almost_empty, count   occupancy in committed wide entries
//   pack_idx        narrow words waiting in the packer
//   ovf, udf        sticky write-while-full / read-while-empty
module fifo_block_pack
   import fifo_block_pack_pkg::*;
#(
   parameter int IN_WH = FIFO_IN_WH,
   parameter int RATIO = FIFO_RATIO,
   parameter int DEPTH = FIFO_DEPTH,
   parameter int AF_TH = 3,
   parameter int AE_TH = 1,
   localparam int OUT_WH = IN_WH * RATIO,
   localparam int AW = clog2(DEPTH),
   localparam int CW = AW + 1,
   localparam int IW = clog2(RATIO)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              flush,
   input  logic              wr_en,
   input  logic [IN_WH-1:0]  wr_data,
   input  logic              rd_en,
   output logic [OUT_WH-1:0] rd_data,
   output logic              rd_valid,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [CW-1:0]     count,
   output logic [IW-1:0]     pack_idx,
   output logic              ovf,
   output logic              udf
);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C = CW'(AF_TH);
   localparam logic [CW-1:0] AE_C = CW'(AE_TH);
   logic [OUT_WH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [OUT_WH-1:0] word;
   logic wr_acc, rd_acc, commit;
   // Flags decode the registered count only, so a same-cycle pop never opens a write slot.
   assign full = count == DEPTH_C;
   assign empty = count == '0;
   assign almost_full = count >= AF_C;
   assign almost_empty = count <= AE_C;
   assign wr_acc = wr_en & ~full & ~flush;
   assign rd_acc = rd_en & ~empty & ~flush;
   fifo_block_pack_lane_packer #(.IN_WH(IN_WH), .RATIO(RATIO)) u_packer (
      .clk      (clk),
      .resetn   (resetn),
      .flush    (flush),
      .accept   (wr_acc),
      .wr_data  (wr_data),
      .pack_idx (pack_idx),
      .commit   (commit),
      .word     (word)
   );
   always_ff @(posedge clk)
      if (commit) mem[wr_ptr] <= word;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         ovf      <= 1'b0;
         udf      <= 1'b0;
      end else if (flush) begin
         rd_valid <= 1'b0;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         ovf      <= 1'b0;
         udf      <= 1'b0;
      end else begin
         rd_valid <= rd_acc;
         if (rd_acc) begin
            rd_data <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + AW'(1);
         end
         if (commit) wr_ptr <= wr_ptr + AW'(1);
         count <= count + CW'(commit) - CW'(rd_acc);
         ovf   <= ovf | (wr_en & full);
         udf   <= udf | (rd_en & empty);
      end
endmodule
